// File: rtl/csi_pkt_tx_if.sv
// rtl/csi_pkt_tx_if.sv - request, payload and byte-stream handshakes of the CSI-2 packet builder
interface csi_pkt_tx_if;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [7:0]  pkt_di;
  logic [15:0] pkt_wc;
  logic        pay_valid;
  logic        pay_ready;
  logic [7:0]  pay_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_sop;
  logic        out_eop;

  modport master (
    output pkt_valid, pkt_di, pkt_wc, pay_valid, pay_data, out_ready,
    input  pkt_ready, pay_ready, out_valid, out_data, out_sop, out_eop
  );

  modport slave (
    input  pkt_valid, pkt_di, pkt_wc, pay_valid, pay_data, out_ready,
    output pkt_ready, pay_ready, out_valid, out_data, out_sop, out_eop
  );
endinterface

// File: rtl/csi_pkt_tx.sv
// rtl/csi_pkt_tx.sv - CSI-2 packet builder: header+ECC, payload, footer as a byte stream
// Optional CRC-16 footer enabled by CSI_PKT_TX_CRC_EN; otherwise the footer is zero.
module csi_pkt_tx #(
  parameter logic [5:0] SHORT_DT_MAX = 6'h0F,
  parameter int         WC_W         = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  csi_pkt_tx_if.slave    bus,
  output logic           tx_busy
);

  typedef enum logic [1:0] {IDLE, HDR, PAY, CRC} state_t;

  state_t          state_q, state_n;
  logic [1:0]      idx_q, idx_n;
  logic [7:0]      di_q, di_n;
  logic [WC_W-1:0] wc_q, wc_n;
  logic [WC_W-1:0] rem_q, rem_n;
  logic            out_valid_q, out_valid_n;
  logic [7:0]      out_data_q, out_data_n;
  logic            out_sop_q, out_sop_n;
  logic            out_eop_q, out_eop_n;
  logic            busy_q, busy_n;
  logic            pkt_ready_q, pkt_ready_n;
  logic            pay_ready_c;
  logic            load;
  logic            is_short;
  logic [7:0]      ecc;
  logic [15:0]     footer;

  function automatic logic [7:0] ecc_calc(input logic [23:0] d);
    logic [7:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = (^d[9:4]) ^ (^d[20:16]) ^ d[22] ^ d[23];
    p[5] = (^d[19:10]) ^ d[21] ^ d[22] ^ d[23];
    p[7:6] = 2'b00;
    return p;
  endfunction

`ifdef CSI_PKT_TX_CRC_EN
  logic [15:0] crc_q, crc_n;

  // Reflected CRC-16/CCITT, one payload byte per call, LSB first.
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign footer = crc_q;
`else
  assign footer = 16'h0000;
`endif

  assign is_short = (di_q[5:0] <= SHORT_DT_MAX);
  assign ecc      = ecc_calc({wc_q[15:0], di_q});
  assign load     = !out_valid_q || bus.out_ready;

  always_comb begin
    state_n     = state_q;
    idx_n       = idx_q;
    di_n        = di_q;
    wc_n        = wc_q;
    rem_n       = rem_q;
    out_valid_n = out_valid_q;
    out_data_n  = out_data_q;
    out_sop_n   = out_sop_q;
    out_eop_n   = out_eop_q;
    busy_n      = busy_q;
    pay_ready_c = 1'b0;
`ifdef CSI_PKT_TX_CRC_EN
    crc_n       = crc_q;
`endif
    if (load) begin
      out_valid_n = 1'b0;
      out_sop_n   = 1'b0;
      out_eop_n   = 1'b0;
    end
    if (out_valid_q && bus.out_ready && out_eop_q) busy_n = 1'b0;

    case (state_q)
      IDLE: begin
        // busy_q low guarantees the output register is already empty here
        if (bus.pkt_valid && pkt_ready_q) begin
          di_n        = bus.pkt_di;
          wc_n        = bus.pkt_wc;
          out_valid_n = 1'b1;
          out_data_n  = bus.pkt_di;
          out_sop_n   = 1'b1;
          busy_n      = 1'b1;
          idx_n       = 2'd1;
          state_n     = HDR;
`ifdef CSI_PKT_TX_CRC_EN
          crc_n       = 16'hFFFF;
`endif
        end
      end
      HDR: begin
        if (load) begin
          out_valid_n = 1'b1;
          idx_n       = idx_q + 2'd1;
          case (idx_q)
            2'd1:    out_data_n = wc_q[7:0];
            2'd2:    out_data_n = wc_q[15:8];
            default: begin
              out_data_n = ecc;
              out_eop_n  = is_short;
              idx_n      = 2'd0;
              rem_n      = wc_q;
              if (is_short)        state_n = IDLE;
              else if (wc_q == '0) state_n = CRC;
              else                 state_n = PAY;
            end
          endcase
        end
      end
      PAY: begin
        pay_ready_c = load;
        if (load && bus.pay_valid) begin
          out_valid_n = 1'b1;
          out_data_n  = bus.pay_data;
          rem_n       = rem_q - WC_W'(1);
`ifdef CSI_PKT_TX_CRC_EN
          crc_n       = crc_upd(crc_q, bus.pay_data);
`endif
          if (rem_q == WC_W'(1)) state_n = CRC;
        end
      end
      default: begin
        if (load) begin
          out_valid_n = 1'b1;
          if (idx_q == 2'd0) begin
            out_data_n = footer[7:0];
            idx_n      = 2'd1;
          end else begin
            out_data_n = footer[15:8];
            out_eop_n  = 1'b1;
            idx_n      = 2'd0;
            state_n    = IDLE;
          end
        end
      end
    endcase

    // Holding off until the eop byte has left keeps one idle cycle between packets.
    pkt_ready_n = (state_n == IDLE) && !busy_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      di_q        <= 8'h00;
      wc_q        <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      busy_q      <= 1'b0;
      pkt_ready_q <= 1'b0;
`ifdef CSI_PKT_TX_CRC_EN
      crc_q       <= 16'hFFFF;
`endif
    end else begin
      state_q     <= state_n;
      idx_q       <= idx_n;
      di_q        <= di_n;
      wc_q        <= wc_n;
      rem_q       <= rem_n;
      out_valid_q <= out_valid_n;
      out_data_q  <= out_data_n;
      out_sop_q   <= out_sop_n;
      out_eop_q   <= out_eop_n;
      busy_q      <= busy_n;
      pkt_ready_q <= pkt_ready_n;
`ifdef CSI_PKT_TX_CRC_EN
      crc_q       <= crc_n;
`endif
    end
  end

  assign bus.pkt_ready = pkt_ready_q;
  assign bus.pay_ready = pay_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign tx_busy       = busy_q;

endmodule
